// File: rtl/sia_pkg.sv
// rtl/sia_pkg.sv - shared receiver state type and synchroniser depth for the SIA receive queue
package sia_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_SHIFT,
    ST_COMMIT
  } rx_state_e;

  localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/sia_rxq_v2_if.sv
// rtl/sia_rxq_v2_if.sv - host-side receive queue control and status bundle
interface sia_rxq_v2_if #(
  parameter int DEPTH_BITS = 2,
  parameter int DATA_BITS  = 12
);

  logic [DEPTH_BITS:0]  thresh_i;
  logic                 rxq_pop_i;
  logic                 rxq_oe_i;
  logic                 rxq_err_clr_i;
  logic [DATA_BITS-1:0] rxq_dat_o;
  logic [DEPTH_BITS:0]  rxq_level_o;
  logic                 rxq_full_o;
  logic                 rxq_not_empty_o;
  logic                 rxq_thresh_o;
  logic                 rxq_ovr_o;
  logic                 rxq_ferr_o;

  modport master (
    output thresh_i, rxq_pop_i, rxq_oe_i, rxq_err_clr_i,
    input  rxq_dat_o, rxq_level_o, rxq_full_o, rxq_not_empty_o,
    input  rxq_thresh_o, rxq_ovr_o, rxq_ferr_o
  );

  modport slave (
    input  thresh_i, rxq_pop_i, rxq_oe_i, rxq_err_clr_i,
    output rxq_dat_o, rxq_level_o, rxq_full_o, rxq_not_empty_o,
    output rxq_thresh_o, rxq_ovr_o, rxq_ferr_o
  );

endinterface

// File: rtl/sia_rxq_fifo.sv
// rtl/sia_rxq_fifo.sv - receive word storage with level, threshold and sticky overrun
module sia_rxq_fifo
  import sia_pkg::*;
#(
  parameter int DEPTH_BITS = 2,
  parameter int DATA_BITS  = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [DATA_BITS-1:0] push_data,
  input  logic                 pop,
  input  logic                 err_clr,
  input  logic [DEPTH_BITS:0]  thresh,
  output logic [DATA_BITS-1:0] rd_data,
  output logic [DEPTH_BITS:0]  level,
  output logic                 full,
  output logic                 not_empty,
  output logic                 thresh_hit,
  output logic                 ovr
);

  localparam int ENTRIES = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] FULL_LEVEL = (DEPTH_BITS+1)'(ENTRIES);

  logic [DATA_BITS-1:0]  mem [ENTRIES];
  logic [DEPTH_BITS-1:0] wr_ptr;
  logic [DEPTH_BITS-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full       = (level == FULL_LEVEL);
  assign not_empty  = (level != '0);
  assign thresh_hit = (level >= thresh);
  assign rd_data    = mem[rd_ptr];

  // A pop in the same cycle frees the slot, so a push into a full queue still lands.
  assign do_pop  = pop && not_empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovr    <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + DEPTH_BITS'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + DEPTH_BITS'(1);
      end
      if (do_push && !do_pop) begin
        level <= level + (DEPTH_BITS+1)'(1);
      end else if (do_pop && !do_push) begin
        level <= level - (DEPTH_BITS+1)'(1);
      end
      if (push && !do_push) begin
        ovr <= 1'b1;
      end else if (err_clr) begin
        ovr <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sia_rxq_v2.sv
// rtl/sia_rxq_v2.sv - oversampling serial receiver feeding a buffered receive queue
// Stop-bit checking is built in when SIA_RXQ_FRAME_CHECK_EN is defined.
module sia_rxq_v2
  import sia_pkg::*;
#(
  parameter int SHIFT_REG_WIDTH = 12,
  parameter int BAUD_RATE_WIDTH = 32,
  parameter int DEPTH_BITS      = 2,
  parameter int DATA_BITS       = 12
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic [5:0]                 bits_i,
  input  logic [BAUD_RATE_WIDTH-1:0] baud_i,
  input  logic                       rxd_i,
  sia_rxq_v2_if.slave                rxq
);

  logic [SYNC_DEPTH-1:0]      sync_q;
  logic                       rxd;
  logic                       rxd_q;
  logic                       fall;
  rx_state_e                  state_q;
  rx_state_e                  state_d;
  logic [BAUD_RATE_WIDTH-1:0] cnt_q;
  logic [BAUD_RATE_WIDTH-1:0] baud_q;
  logic [5:0]                 bit_cnt_q;
  logic [SHIFT_REG_WIDTH-1:0] sr_q;
  logic                       cnt_zero;
  logic                       start_load;
  logic                       shift_en;
  logic                       push;
  logic [DATA_BITS-1:0]       rd_data;

  assign rxd      = sync_q[SYNC_DEPTH-1];
  assign fall     = rxd_q && !rxd;
  assign cnt_zero = (cnt_q == '0);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sync_q  <= '1;
      rxd_q   <= 1'b1;
      state_q <= ST_IDLE;
    end else begin
      sync_q  <= {sync_q[SYNC_DEPTH-2:0], rxd_i};
      rxd_q   <= rxd;
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    start_load = 1'b0;
    shift_en   = 1'b0;
    push       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (fall) begin
          start_load = 1'b1;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        if (cnt_zero) begin
          if (rxd) begin
            state_d = ST_IDLE;
          end else begin
            shift_en = 1'b1;
            state_d  = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        if (cnt_zero) begin
          shift_en = 1'b1;
          if (bit_cnt_q == 6'd1) begin
            state_d = ST_COMMIT;
          end
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
`ifdef SIA_RXQ_FRAME_CHECK_EN
        push = sr_q[SHIFT_REG_WIDTH-1];
`else
        push = 1'b1;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // First wait is half a bit period so every later sample lands mid-bit.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt_q     <= '0;
      baud_q    <= '0;
      bit_cnt_q <= '0;
      sr_q      <= '1;
    end else if (start_load) begin
      baud_q    <= baud_i;
      cnt_q     <= baud_i >> 1;
      bit_cnt_q <= bits_i;
      sr_q      <= '1;
    end else if (shift_en) begin
      sr_q      <= {rxd, sr_q[SHIFT_REG_WIDTH-1:1]};
      cnt_q     <= baud_q;
      bit_cnt_q <= bit_cnt_q - 6'd1;
    end else if (state_q == ST_START || state_q == ST_SHIFT) begin
      cnt_q <= cnt_q - BAUD_RATE_WIDTH'(1);
    end
  end

`ifdef SIA_RXQ_FRAME_CHECK_EN
  logic ferr_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      ferr_q <= 1'b0;
    end else if (state_q == ST_COMMIT && !sr_q[SHIFT_REG_WIDTH-1]) begin
      ferr_q <= 1'b1;
    end else if (rxq.rxq_err_clr_i) begin
      ferr_q <= 1'b0;
    end
  end

  assign rxq.rxq_ferr_o = ferr_q;
`else
  assign rxq.rxq_ferr_o = 1'b0;
`endif

  sia_rxq_fifo #(
    .DEPTH_BITS(DEPTH_BITS),
    .DATA_BITS (DATA_BITS)
  ) u_fifo (
    .clk       (clk_i),
    .rst_n     (reset_ni),
    .push      (push),
    .push_data (sr_q[SHIFT_REG_WIDTH-1 -: DATA_BITS]),
    .pop       (rxq.rxq_pop_i),
    .err_clr   (rxq.rxq_err_clr_i),
    .thresh    (rxq.thresh_i),
    .rd_data   (rd_data),
    .level     (rxq.rxq_level_o),
    .full      (rxq.rxq_full_o),
    .not_empty (rxq.rxq_not_empty_o),
    .thresh_hit(rxq.rxq_thresh_o),
    .ovr       (rxq.rxq_ovr_o)
  );

  assign rxq.rxq_dat_o = rxq.rxq_oe_i ? rd_data : '0;

endmodule
